// File: rtl/dummy_if.sv
// Flit, valid, credit and route signals for the five ports (L, N, E, S, W) of one mesh router.
// master = the neighbours/host side, slave = the router.
interface dummy_if #(
    parameter int DW = 8
);
    logic [DW-1:0] Data_in_L, Data_in_N, Data_in_E, Data_in_S, Data_in_W;
    logic          val_in_L, val_in_N, val_in_E, val_in_S, val_in_W;
    logic          ret_in_L, ret_in_N, ret_in_E, ret_in_S, ret_in_W;
    logic [DW-1:0] Data_out_L, Data_out_N, Data_out_E, Data_out_S, Data_out_W;
    logic          val_out_L, val_out_N, val_out_E, val_out_S, val_out_W;
    logic          ret_out_L, ret_out_N, ret_out_E, ret_out_S, ret_out_W;
    logic          full_L, full_N, full_E, full_S, full_W;
    logic [2:0]    r_L, r_N, r_E, r_S, r_W;

    modport master (
        output Data_in_L, Data_in_N, Data_in_E, Data_in_S, Data_in_W,
        output val_in_L, val_in_N, val_in_E, val_in_S, val_in_W,
        output ret_out_L, ret_out_N, ret_out_E, ret_out_S, ret_out_W,
        output full_L, full_N, full_E, full_S, full_W,
        input  ret_in_L, ret_in_N, ret_in_E, ret_in_S, ret_in_W,
        input  Data_out_L, Data_out_N, Data_out_E, Data_out_S, Data_out_W,
        input  val_out_L, val_out_N, val_out_E, val_out_S, val_out_W,
        input  r_L, r_N, r_E, r_S, r_W
    );

    modport slave (
        input  Data_in_L, Data_in_N, Data_in_E, Data_in_S, Data_in_W,
        input  val_in_L, val_in_N, val_in_E, val_in_S, val_in_W,
        input  ret_out_L, ret_out_N, ret_out_E, ret_out_S, ret_out_W,
        input  full_L, full_N, full_E, full_S, full_W,
        output ret_in_L, ret_in_N, ret_in_E, ret_in_S, ret_in_W,
        output Data_out_L, Data_out_N, Data_out_E, Data_out_S, Data_out_W,
        output val_out_L, val_out_N, val_out_E, val_out_S, val_out_W,
        output r_L, r_N, r_E, r_S, r_W
    );
endinterface

// File: rtl/dummy.sv
// 5-port XY mesh router: per-input FIFO, per-output round-robin arbiter, registered outputs.
// Port index everywhere equals the route code: L=0, N=1, E=2, S=3, W=4.
module dummy #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] X_address,
    input  logic [1:0] Y_address,
    dummy_if.slave     nif
);
    localparam int NP = 5;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [2:0] P_L = 3'd0;
    localparam logic [2:0] P_N = 3'd1;
    localparam logic [2:0] P_E = 3'd2;
    localparam logic [2:0] P_S = 3'd3;
    localparam logic [2:0] P_W = 3'd4;
    localparam logic [2:0] R_NONE = 3'd7;

    function automatic logic [2:0] xy_route(input logic [DW-1:0] flit,
                                            input logic [1:0] my_x,
                                            input logic [1:0] my_y);
        logic [1:0] dst_x;
        logic [1:0] dst_y;
        dst_x = flit[3:2];
        dst_y = flit[1:0];
        if (dst_x > my_x)      return P_E;
        else if (dst_x < my_x) return P_W;
        else if (dst_y > my_y) return P_S;
        else if (dst_y < my_y) return P_N;
        else                   return P_L;
    endfunction

    // First requester at or after ptr wins, wrapping around.
    function automatic logic [NP-1:0] rr_pick(input logic [NP-1:0] req_vec,
                                              input logic [2:0] ptr);
        logic [NP-1:0] pick;
        pick = '0;
        for (int i = 0; i < NP; i++)
            if (pick == '0 && req_vec[i] && i >= int'(ptr)) pick[i] = 1'b1;
        for (int i = 0; i < NP; i++)
            if (pick == '0 && req_vec[i] && i < int'(ptr)) pick[i] = 1'b1;
        return pick;
    endfunction

    // Reset asserts asynchronously, releases on the second clk edge.
    logic rst_meta_p0, rst_n_p1;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta_p0 <= 1'b0;
            rst_n_p1    <= 1'b0;
        end else begin
            rst_meta_p0 <= 1'b1;
            rst_n_p1    <= rst_meta_p0;
        end
    end

    logic [DW-1:0] din  [NP];
    logic [NP-1:0] vin, rout, full_dn;

    assign din[0] = nif.Data_in_L;
    assign din[1] = nif.Data_in_N;
    assign din[2] = nif.Data_in_E;
    assign din[3] = nif.Data_in_S;
    assign din[4] = nif.Data_in_W;
    assign vin     = {nif.val_in_W, nif.val_in_S, nif.val_in_E, nif.val_in_N, nif.val_in_L};
    assign rout    = {nif.ret_out_W, nif.ret_out_S, nif.ret_out_E, nif.ret_out_N, nif.ret_out_L};
    assign full_dn = {nif.full_W, nif.full_S, nif.full_E, nif.full_N, nif.full_L};

    logic [DW-1:0] mem    [NP][DEPTH];
    logic [AW:0]   wr_ptr [NP];
    logic [AW:0]   rd_ptr [NP];
    logic [DW-1:0] head   [NP];
    logic [2:0]    route  [NP];
    logic [NP-1:0] empty, fifo_full, push, pop;

    always_comb begin
        empty     = '0;
        fifo_full = '0;
        for (int p = 0; p < NP; p++) begin
            head[p]      = mem[p][rd_ptr[p][AW-1:0]];
            empty[p]     = (wr_ptr[p] == rd_ptr[p]);
            fifo_full[p] = ((wr_ptr[p] - rd_ptr[p]) == FULL_CNT);
            route[p]     = empty[p] ? R_NONE : xy_route(head[p], X_address, Y_address);
        end
    end

    logic [NP-1:0] ready;
    logic [NP-1:0] req      [NP];
    logic [NP-1:0] gnt      [NP];
    logic [2:0]    rr_ptr   [NP];
    logic [2:0]    rr_next  [NP];
    logic [DW-1:0] sel_data [NP];

    // gnt[o][i]: output o takes the head of input i. A head routes to one
    // output only, so no input can be granted twice in a cycle.
    always_comb begin
        ready = '0;
        pop   = '0;
        for (int o = 0; o < NP; o++) begin
            req[o]      = '0;
            ready[o]    = ~full_dn[o] | rout[o];
            for (int i = 0; i < NP; i++)
                req[o][i] = ~empty[i] & (route[i] == 3'(o)) & ready[o];
            gnt[o]      = rr_pick(req[o], rr_ptr[o]);
            pop         = pop | gnt[o];
            sel_data[o] = '0;
            rr_next[o]  = rr_ptr[o];
            for (int i = 0; i < NP; i++) begin
                if (gnt[o][i]) begin
                    sel_data[o] = head[i];
                    rr_next[o]  = (i == NP - 1) ? P_L : 3'(i + 1);
                end
            end
        end
    end

    // A pop in the same cycle frees the slot for a write into a full FIFO.
    assign push = vin & (~fifo_full | pop);

    always_ff @(posedge clk or negedge rst_n_p1) begin
        if (!rst_n_p1) begin
            for (int p = 0; p < NP; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++)
            if (push[p]) mem[p][wr_ptr[p][AW-1:0]] <= din[p];
    end

    // ---- stage p1: registered output flits, valids and credit returns ----
    logic [DW-1:0] data_out_p1 [NP];
    logic [NP-1:0] vld_out_p1, ret_in_p1;

    always_ff @(posedge clk or negedge rst_n_p1) begin
        if (!rst_n_p1) begin
            for (int o = 0; o < NP; o++) begin
                data_out_p1[o] <= '0;
                rr_ptr[o]      <= P_L;
            end
            vld_out_p1 <= '0;
            ret_in_p1  <= '0;
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (|gnt[o]) data_out_p1[o] <= sel_data[o];
                rr_ptr[o]     <= rr_next[o];
                vld_out_p1[o] <= |gnt[o];
            end
            ret_in_p1 <= pop;
        end
    end

    assign nif.Data_out_L = data_out_p1[0];
    assign nif.Data_out_N = data_out_p1[1];
    assign nif.Data_out_E = data_out_p1[2];
    assign nif.Data_out_S = data_out_p1[3];
    assign nif.Data_out_W = data_out_p1[4];
    assign nif.val_out_L  = vld_out_p1[0];
    assign nif.val_out_N  = vld_out_p1[1];
    assign nif.val_out_E  = vld_out_p1[2];
    assign nif.val_out_S  = vld_out_p1[3];
    assign nif.val_out_W  = vld_out_p1[4];
    assign nif.ret_in_L   = ret_in_p1[0];
    assign nif.ret_in_N   = ret_in_p1[1];
    assign nif.ret_in_E   = ret_in_p1[2];
    assign nif.ret_in_S   = ret_in_p1[3];
    assign nif.ret_in_W   = ret_in_p1[4];
    assign nif.r_L        = route[0];
    assign nif.r_N        = route[1];
    assign nif.r_E        = route[2];
    assign nif.r_S        = route[3];
    assign nif.r_W        = route[4];
endmodule

// File: tb/tb_dummy.sv
// Bench for the mesh router: queue-based reference model feeds a scoreboard, a monitor checks every cycle.
`timescale 1ns/1ps
module tb_dummy;
    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int NP    = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] x_addr = 2'd0;
    logic [1:0] y_addr = 2'd0;

    dummy_if #(.DW(DW)) nif ();
    dummy #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst(rst), .X_address(x_addr), .Y_address(y_addr), .nif(nif)
    );

    always #5 clk = ~clk;

    logic [7:0]    din [NP];
    logic [NP-1:0] vin, full, rout;
    logic [7:0]    dout [NP];
    logic [NP-1:0] vout, rin;
    logic [14:0]   r_all;

    assign nif.Data_in_L = din[0];
    assign nif.Data_in_N = din[1];
    assign nif.Data_in_E = din[2];
    assign nif.Data_in_S = din[3];
    assign nif.Data_in_W = din[4];
    assign {nif.val_in_W, nif.val_in_S, nif.val_in_E, nif.val_in_N, nif.val_in_L} = vin;
    assign {nif.full_W, nif.full_S, nif.full_E, nif.full_N, nif.full_L} = full;
    assign {nif.ret_out_W, nif.ret_out_S, nif.ret_out_E, nif.ret_out_N, nif.ret_out_L} = rout;
    assign dout[0] = nif.Data_out_L;
    assign dout[1] = nif.Data_out_N;
    assign dout[2] = nif.Data_out_E;
    assign dout[3] = nif.Data_out_S;
    assign dout[4] = nif.Data_out_W;
    assign vout  = {nif.val_out_W, nif.val_out_S, nif.val_out_E, nif.val_out_N, nif.val_out_L};
    assign rin   = {nif.ret_in_W, nif.ret_in_S, nif.ret_in_E, nif.ret_in_N, nif.ret_in_L};
    assign r_all = {nif.r_W, nif.r_S, nif.r_E, nif.r_N, nif.r_L};

    typedef struct packed {
        logic [4:0]  val;
        logic [4:0]  ret;
        logic [14:0] rts;
    } ctl_t;

    logic [7:0] mq       [NP][$];  // model contents of each input FIFO
    logic [7:0] exp_data [NP][$];  // flits each output still owes
    ctl_t       ctl_q    [$];      // per-cycle valid / credit / route expectations
    int         rr       [NP];     // next input each output favours

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_val);
        n_checks++;
        if (act === req_val) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req_val, $time);
    endtask

    function automatic int model_route(input logic [7:0] f);
        int dx, dy, mx, my;
        dx = int'(f[3:2]);
        dy = int'(f[1:0]);
        mx = int'(x_addr);
        my = int'(y_addr);
        if (dx != mx) return (dx > mx) ? 2 : 4;
        if (dy != my) return (dy > my) ? 3 : 1;
        return 0;
    endfunction

    // Called at a negedge with inputs already set: predicts the next edge, then advances one cycle.
    task automatic tick();
        ctl_t c;
        logic [NP-1:0] granted;
        c = '0;
        granted = '0;
        for (int o = 0; o < NP; o++) begin
            if (full[o] && !rout[o]) continue;
            for (int k = 0; k < NP; k++) begin
                int i;
                i = (rr[o] + k) % NP;
                if (mq[i].size() > 0 && model_route(mq[i][0]) == o) begin
                    exp_data[o].push_back(mq[i][0]);
                    granted[i] = 1'b1;
                    c.val[o]   = 1'b1;
                    c.ret[i]   = 1'b1;
                    rr[o]      = (i + 1) % NP;
                    break;
                end
            end
        end
        for (int i = 0; i < NP; i++)
            if (granted[i]) void'(mq[i].pop_front());
        for (int i = 0; i < NP; i++)
            if (vin[i] && mq[i].size() < DEPTH) mq[i].push_back(din[i]);
        for (int i = 0; i < NP; i++)
            c.rts[3*i +: 3] = (mq[i].size() > 0) ? 3'(model_route(mq[i][0])) : 3'd7;
        ctl_q.push_back(c);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_in();
        for (int i = 0; i < NP; i++) din[i] = 8'h00;
        vin  = '0;
        full = '0;
        rout = '0;
    endtask

    task automatic drain();
        clear_in();
        repeat (DEPTH * NP + 4) tick();
    endtask

    task automatic reset_model();
        for (int i = 0; i < NP; i++) begin
            mq[i].delete();
            exp_data[i].delete();
            rr[i] = 0;
        end
        ctl_q.delete();
    endtask

    task automatic check_idle(input string tag);
        logic [39:0] d_all;
        d_all = {dout[4], dout[3], dout[2], dout[1], dout[0]};
        check({tag, " val_out"}, 32'(vout), 32'd0);
        check({tag, " ret_in"}, 32'(rin), 32'd0);
        check({tag, " route"}, 32'(r_all), 32'h7fff);
        check({tag, " data_out[31:0]"}, d_all[31:0], 32'd0);
        check({tag, " data_out[39:32]"}, 32'(d_all[39:32]), 32'd0);
    endtask

    // Monitor: one expectation record per edge; data is popped per output only when valid shows.
    initial begin
        ctl_t c;
        forever begin
            @(posedge clk);
            #1;
            if (ctl_q.size() > 0) begin
                c = ctl_q.pop_front();
                check("val_out", 32'(vout), 32'(c.val));
                check("ret_in", 32'(rin), 32'(c.ret));
                check("route", 32'(r_all), 32'(c.rts));
                for (int o = 0; o < NP; o++) begin
                    if (vout[o]) begin
                        if (exp_data[o].size() == 0) begin
                            check($sformatf("extra flit out %0d", o), 32'(dout[o]), 32'hffff_ffff);
                        end else begin
                            check($sformatf("data_out %0d", o), 32'(dout[o]), 32'(exp_data[o].pop_front()));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_model();
        // Reset held with traffic offered
        for (int i = 0; i < NP; i++) din[i] = 8'h0F;
        vin  = '1;
        full = '0;
        rout = '0;
        #1;
        check_idle("reset");
        repeat (3) @(negedge clk);
        check_idle("reset held");
        rst = 1'b1;
        clear_in();
        repeat (4) @(negedge clk);
        check_idle("after release");

        // Single flit L -> E at (0,0)
        x_addr = 2'd0;
        y_addr = 2'd0;
        din[0] = 8'h0F;
        vin[0] = 1'b1;
        tick();
        clear_in();
        repeat (4) tick();

        // Five-way contention for E, two flits each
        din[0] = 8'h0F;
        din[1] = 8'h1F;
        din[2] = 8'h3F;
        din[3] = 8'h4F;
        din[4] = 8'h5F;
        vin = '1;
        repeat (2) tick();
        drain();

        // Backpressure on E: FIFO L fills, extras drop, one credit frees one flit
        full[2] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            din[0] = 8'(k << 4) | 8'h0F;
            vin[0] = 1'b1;
            tick();
        end
        vin[0]  = 1'b0;
        rout[2] = 1'b1;
        tick();
        rout[2] = 1'b0;
        repeat (3) tick();
        drain();

        // All five directions at once from (1,1)
        x_addr = 2'd1;
        y_addr = 2'd1;
        din[0] = 8'h19;
        din[1] = 8'h21;
        din[2] = 8'h36;
        din[3] = 8'h44;
        din[4] = 8'h55;
        vin = '1;
        tick();
        drain();

        // Randomised traffic at random node positions
        for (int ph = 0; ph < 4; ph++) begin
            x_addr = 2'($urandom_range(0, 3));
            y_addr = 2'($urandom_range(0, 3));
            for (int n = 0; n < 300; n++) begin
                for (int i = 0; i < NP; i++) begin
                    din[i]  = 8'($urandom);
                    vin[i]  = ($urandom_range(0, 9) < 7);
                    full[i] = ($urandom_range(0, 9) < 3);
                    rout[i] = ($urandom_range(0, 9) < 3);
                end
                tick();
            end
            drain();
        end

        // Asynchronous reset while FIFOs hold flits
        x_addr = 2'd0;
        y_addr = 2'd0;
        full = '1;
        vin  = '1;
        for (int i = 0; i < NP; i++) din[i] = 8'($urandom) | 8'h0C;
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        check_idle("async reset");
        reset_model();
        @(negedge clk);
        rst = 1'b1;
        clear_in();
        repeat (4) @(negedge clk);
        check_idle("after async reset");
        for (int n = 0; n < 100; n++) begin
            for (int i = 0; i < NP; i++) begin
                din[i]  = 8'($urandom);
                vin[i]  = ($urandom_range(0, 9) < 6);
                full[i] = ($urandom_range(0, 9) < 2);
                rout[i] = ($urandom_range(0, 9) < 5);
            end
            tick();
        end
        drain();

        @(posedge clk);
        #2;
        for (int o = 0; o < NP; o++)
            check($sformatf("undelivered flits out %0d", o), 32'(exp_data[o].size()), 32'd0);
        check("pending cycle records", 32'(ctl_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
